// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the register-file write arbiter
package rf_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int RF_ADDR_W   = 2;
    localparam int RF_NUM_REGS = 4;

    // Requester id assignment on the shared write port
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

    localparam int CONFLICT_W = 16;

    // Largest supported requester count; the popcount helper is sized for it
    localparam int MAX_REQ = 4;

    function automatic logic [2:0] count_ones(input logic [MAX_REQ-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - writeback request bundle (valid/ready/addr/data per requester)
//
// master: requester side (drives valid/addr/data, receives ready)
// slave : arbiter side   (receives valid/addr/data, drives ready)
// Slice i of req_addr/req_data belongs to requester i.
interface rf_write_arbiter_if #(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 2,
    parameter int WORD_SIZE = 16
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*ADDR_W-1:0]    req_addr;
    logic [NREQ*WORD_SIZE-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select with registered rotation pointer
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_valid    : per-requester valid
//   i_stall    : downstream write port unavailable; suppresses every grant
//   o_ready    : one-hot grant (all zero when idle, stalled or in reset)
//   o_winner   : index of the granted requester (meaningful when o_fire=1)
//   o_fire     : a transfer happens this cycle
module rr_arbiter #(
    parameter  int NREQ  = 2,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  i_valid,
    input  logic             i_stall,
    output logic [NREQ-1:0]  o_ready,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_fire
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic             w_found;
    int               w_idx;

    // Search starting at r_ptr, wrapping modulo NREQ; first valid wins.
    always_comb begin
        o_ready  = '0;
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        if (!reset && !i_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= NREQ) begin
                    w_idx = w_idx - NREQ;
                end
                if (!w_found && i_valid[w_idx[IDX_W-1:0]]) begin
                    w_found                    = 1'b1;
                    o_winner                   = w_idx[IDX_W-1:0];
                    o_ready[w_idx[IDX_W-1:0]]  = 1'b1;
                end
            end
        end
    end

    // o_ready is only raised on a valid requester, so any grant is a transfer
    assign o_fire = w_found;

    assign w_ptr_next = (o_winner == IDX_W'(NREQ - 1)) ? '0 : o_winner + 1'b1;

    // The pointer only rotates past a requester that actually transferred
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_fire) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin sharing of the register-file write port
//
// Optional feature macro: RF_WB_FORWARD_EN (forward the registered write to the read ports)
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req                  : requester bundle (slave side of rf_write_arbiter_if)
//   rf_stall             : register-file write port unavailable this cycle
//   rf_write/addr/data   : registered register-file write pins
//   grant_id             : index of the last accepted requester
//   conflict_cnt         : saturating count of cycles with >=2 requesters valid
//   rd_addr1/2           : register-file read addresses (used only for forwarding)
//   rf_rdata1/2          : raw register-file read data
//   rd_data1/2           : read data after optional forwarding
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter  int WORD_SIZE = rf_pkg::WORD_SIZE,
    parameter  int ADDR_W    = rf_pkg::RF_ADDR_W,
    parameter  int NREQ      = 2,
    localparam int GID_W     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    rf_write_arbiter_if.slave     req,
    input  logic                  rf_stall,
    output logic                  rf_write,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [WORD_SIZE-1:0]  rf_data,
    output logic [GID_W-1:0]      grant_id,
    output logic [CONFLICT_W-1:0] conflict_cnt,
    input  logic [ADDR_W-1:0]     rd_addr1,
    input  logic [ADDR_W-1:0]     rd_addr2,
    input  logic [WORD_SIZE-1:0]  rf_rdata1,
    input  logic [WORD_SIZE-1:0]  rf_rdata2,
    output logic [WORD_SIZE-1:0]  rd_data1,
    output logic [WORD_SIZE-1:0]  rd_data2
);

    logic [NREQ-1:0]       w_ready;
    logic [GID_W-1:0]      w_winner;
    logic                  w_fire;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [WORD_SIZE-1:0]  w_sel_data;
    logic [MAX_REQ-1:0]    w_valid_ext;
    logic                  w_contention;

    logic                  r_rf_write;
    logic [ADDR_W-1:0]     r_rf_addr;
    logic [WORD_SIZE-1:0]  r_rf_data;
    logic [GID_W-1:0]      r_grant_id;
    logic [CONFLICT_W-1:0] r_conflict_cnt;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (req.req_valid),
        .i_stall  (rf_stall),
        .o_ready  (w_ready),
        .o_winner (w_winner),
        .o_fire   (w_fire)
    );

    assign req.req_ready = w_ready;

    assign w_sel_addr = req.req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
    assign w_sel_data = req.req_data[int'(w_winner)*WORD_SIZE +: WORD_SIZE];

    // Contention is judged on raw valids, independent of stall
    always_comb begin
        w_valid_ext             = '0;
        w_valid_ext[NREQ-1:0]   = req.req_valid;
    end
    assign w_contention = (count_ones(w_valid_ext) >= 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_write     <= 1'b0;
            r_rf_addr      <= '0;
            r_rf_data      <= '0;
            r_grant_id     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_rf_write <= w_fire;
            if (w_fire) begin
                r_rf_addr  <= w_sel_addr;
                r_rf_data  <= w_sel_data;
                r_grant_id <= w_winner;
            end
            if (w_contention && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign rf_write     = r_rf_write;
    assign rf_addr      = r_rf_addr;
    assign rf_data      = r_rf_data;
    assign grant_id     = r_grant_id;
    assign conflict_cnt = r_conflict_cnt;

`ifdef RF_WB_FORWARD_EN
    // The register file commits r_rf_data at this edge; a same-cycle read sees it early
    assign rd_data1 = (r_rf_write && (r_rf_addr == rd_addr1)) ? r_rf_data : rf_rdata1;
    assign rd_data2 = (r_rf_write && (r_rf_addr == rd_addr2)) ? r_rf_data : rf_rdata2;
`else
    assign rd_data1 = rf_rdata1;
    assign rd_data2 = rf_rdata2;

    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^{rd_addr1, rd_addr2};
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int WS   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rf_stall;
    logic          rf_write;
    logic [AW-1:0] rf_addr;
    logic [WS-1:0] rf_data;
    logic          grant_id;
    logic [15:0]   conflict_cnt;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [WS-1:0] rf_rdata1, rf_rdata2, rd_data1, rd_data2;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .WORD_SIZE(WS)) bus ();

    rf_write_arbiter #(.WORD_SIZE(WS), .ADDR_W(AW), .NREQ(NREQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (bus),
        .rf_stall     (rf_stall),
        .rf_write     (rf_write),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .grant_id     (grant_id),
        .conflict_cnt (conflict_cnt),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (what the DUT should present after the next edge)
    logic [17:0]     q[$];
    logic            m_wr        = 1'b0;
    int              m_ptr       = 0;
    int              m_gid       = 0;
    int              m_cnt       = 0;
    logic [AW-1:0]   m_last_addr = '0;
    logic [WS-1:0]   m_last_data = '0;
    logic [NREQ-1:0] acc         = '0;
    logic            chk_en      = 1'b1;

    always @(negedge clk) begin
        logic [17:0]     e;
        logic [NREQ-1:0] er;
        logic [WS-1:0]   erd1, erd2;
        int              w;
        if (m_wr) begin
            e = q.pop_front();
            m_last_addr = e[17:16];
            m_last_data = e[15:0];
        end
`ifdef RF_WB_FORWARD_EN
        erd1 = (m_wr && m_last_addr == rd_addr1) ? m_last_data : rf_rdata1;
        erd2 = (m_wr && m_last_addr == rd_addr2) ? m_last_data : rf_rdata2;
`else
        erd1 = rf_rdata1;
        erd2 = rf_rdata2;
`endif
        if (chk_en) begin
            chk("rf_write", rf_write, m_wr);
            chk("rf_addr", rf_addr, m_last_addr);
            chk("rf_data", rf_data, m_last_data);
            chk("grant_id", grant_id, m_gid);
            chk("conflict_cnt", conflict_cnt, m_cnt);
            chk("rd_data1", rd_data1, erd1);
            chk("rd_data2", rd_data2, erd2);
        end
        er = '0;
        w  = -1;
        if (!reset && !rf_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (w < 0 && bus.req_valid[i]) w = i;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        if (chk_en) chk("req_ready", bus.req_ready, er);
        acc = bus.req_valid & er;
        if (reset) begin
            m_wr = 1'b0; m_ptr = 0; m_gid = 0; m_cnt = 0;
            m_last_addr = '0; m_last_data = '0;
            q.delete();
        end else begin
            if (w >= 0) begin
                q.push_back({bus.req_addr[w*AW +: AW], bus.req_data[w*WS +: WS]});
                m_wr  = 1'b1;
                m_ptr = (w + 1) % NREQ;
                m_gid = w;
            end else begin
                m_wr = 1'b0;
            end
            if ($countones(bus.req_valid) >= 2 && m_cnt < 65535) m_cnt++;
        end
    end

    // Requesters hold a pending offer until accepted; otherwise take a fresh one
    task automatic cyc(input logic [NREQ-1:0] want, input logic stall);
        for (int i = 0; i < NREQ; i++) begin
            if (!(bus.req_valid[i] && !acc[i])) begin
                bus.req_valid[i]         = want[i];
                bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, RF_NUM_REGS - 1));
                bus.req_data[i*WS +: WS] = WS'($urandom);
            end
        end
        rf_stall  = stall;
        rd_addr1  = AW'($urandom);
        rd_addr2  = AW'($urandom);
        rf_rdata1 = WS'($urandom);
        rf_rdata2 = WS'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        rf_stall      = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        rd_addr1      = '0;
        rd_addr2      = '0;
        rf_rdata1     = '0;
        rf_rdata2     = '0;
        @(posedge clk);
        #1;
        cyc('0, 1'b0);
        reset = 1'b0;

        // single ALU write: addr 2, data 0x1234
        bus.req_valid                        = '0;
        bus.req_valid[REQ_ALU]               = 1'b1;
        bus.req_addr[REQ_ALU*AW +: AW]       = 2'd2;
        bus.req_data[REQ_ALU*WS +: WS]       = 16'h1234;
        rf_rdata1 = '0;
        @(posedge clk);
        #1;
        repeat (3) cyc('0, 1'b0);

        // fairness: both requesters continuously valid
        repeat (4) cyc(2'b11, 1'b0);
        repeat (2) cyc(2'b00, 1'b0);

        // stall with both valid, then release
        repeat (3) cyc(2'b11, 1'b1);
        repeat (2) cyc(2'b11, 1'b0);
        repeat (2) cyc(2'b00, 1'b0);

        // reset right after a transfer drops nothing already presented, but clears state
        cyc(2'b01, 1'b0);
        reset = 1'b1;
        cyc(2'b00, 1'b0);
        reset = 1'b0;
        repeat (2) cyc(2'b00, 1'b0);

        // random traffic, including same-address back-to-back writes from the LOAD port
        repeat (300) cyc(NREQ'($urandom), ($urandom_range(0, 3) == 0));
        repeat (3) cyc(2'b00, 1'b0);

        // counter saturation under continuous contention
        reset = 1'b1;
        cyc(2'b11, 1'b1);
        reset  = 1'b0;
        chk_en = 1'b0;
        repeat (65540) cyc(2'b11, 1'b1);
        chk_en = 1'b1;
        repeat (2) cyc(2'b11, 1'b1);
        chk("conflict_sat", conflict_cnt, 32'hFFFF);
        repeat (2) cyc(2'b11, 1'b0);
        chk("conflict_hold", conflict_cnt, 32'hFFFF);
        repeat (3) cyc(2'b00, 1'b0);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the 4x16-bit register file between several writeback requesters, e.g. ALU writeback (requester 0) and load writeback (requester 1). Each requester offers a valid/ready handshake. A round-robin arbiter picks one requester per cycle, and the granted write goes through one registered stage that drives the register file's write, address and data pins. The block also counts write-port contention cycles, and can optionally forward the in-flight write to the register file's read ports.

## Interface
Parameters:
- WORD_SIZE, 16, data width of one register.
- ADDR_W, 2, register address width.
- NREQ, 2, number of requesters (2..4).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i offers a write.
- req_ready  out  NREQ  bit i: requester i's write is accepted this cycle.
- req_addr  in  NREQ*ADDR_W  target register, slice i belongs to requester i.
- req_data  in  NREQ*WORD_SIZE  write data, slice i belongs to requester i.
- rf_stall  in  1  register file write port unavailable this cycle.
- rf_write  out  1  register file write enable.
- rf_addr  out  ADDR_W  register file write address.
- rf_data  out  WORD_SIZE  register file write data.
- grant_id  out  clog2(NREQ)  index of the last accepted requester.
- conflict_cnt  out  16  count of cycles with two or more req_valid bits set.
- rd_addr1, rd_addr2  in  ADDR_W  register file read addresses (forwarding).
- rf_rdata1, rf_rdata2  in  WORD_SIZE  raw register file read data.
- rd_data1, rd_data2  out  WORD_SIZE  read data after optional forwarding.

## Operation
- Requester contract: once req_valid[i] rises, req_addr/req_data slice i stay stable until the cycle in which req_ready[i]=1.
- Arbitration (combinational):
  - With rf_stall=0, the winner is the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready is one-hot on the winner, or all zero if nothing is valid or rf_stall=1.
  - req_ready never depends on rf_write.
- Transfer: a requester transfers when req_valid[i] && req_ready[i]. At most one transfer happens per cycle.
- State updates on a transfer:
  - rr_ptr <= (winner+1) mod NREQ.
  - grant_id <= winner.
  - Output stage loads: rf_write <= 1, rf_addr <= req_addr slice, rf_data <= req_data slice.
- State updates with no transfer: rf_write <= 0, and rf_addr/rf_data hold their values. rr_ptr does not move on stall or idle cycles.
- Contention counter: conflict_cnt increments in any cycle with popcount(req_valid) >= 2, whether or not rf_stall is set. It saturates at 0xFFFF.
- Same address from different requesters in consecutive transfers: both writes are issued in order, and the later transfer wins in the register file.
- rd_data1/rd_data2: see Configuration.

## Timing
- Latency: a transfer in cycle N produces rf_write=1 with its addr/data in cycle N+1. The register file updates at the end of N+1.
- Throughput: one write per cycle while any requester is valid and rf_stall=0.
- rf_stall=1 in cycle N: no transfer in N, so rf_write=0 in N+1. A write already registered in N is still presented in N.
- Reset (synchronous), output values:
  - rf_write=0, rf_addr=0, rf_data=0.
  - grant_id=0, rr_ptr=0, conflict_cnt=0.
  - req_ready=0 during the reset cycle.
- Reset mid-operation: a pending registered write is dropped (rf_write=0 in the next cycle). Requesters must re-present after reset.

## Configuration
- Macro: RF_WB_FORWARD_EN.
- Defined: rd_dataK = rf_data when rf_write && rf_addr==rd_addrK, else rf_rdataK. This lets a same-cycle read see the write the register file commits at this clock edge.
- Undefined: rd_dataK = rf_rdataK (pass-through), and rd_addr1/rd_addr2 are unused.
- Ports exist in both builds.

## Structure
- Shared package rf_pkg holds:
  - WORD_SIZE, RF_ADDR_W=2, RF_NUM_REGS=4.
  - Requester id constants REQ_ALU=0, REQ_LOAD=1.
  - Counter width CONFLICT_W=16.
- Sub-module rr_arbiter contains the combinational round-robin winner select plus the registered rr_ptr. The top level adds the output stage, the counter and forwarding.

## Test plan
- Single requester: req0 valid, addr=2, data=0x1234 in cycle 0 → req_ready=01 in cycle 0; cycle 1 shows rf_write=1, rf_addr=2, rf_data=0x1234; cycle 2 shows rf_write=0.
- Round-robin fairness: both requesters valid continuously for 4 transfers from reset → grants go 0,1,0,1; conflict_cnt=4; rf_write high for 4 consecutive cycles.
- Stall: both valid, rf_stall=1 for 3 cycles → req_ready=00 for those cycles, rf_write=0, rr_ptr unchanged, conflict_cnt still +3; the first grant after the stall goes to requester 0.
- Reset mid-flight: transfer in cycle N, reset=1 in cycle N+1 → in N+2 rf_write=0, rf_data=0, conflict_cnt=0, grant_id=0.
- Forwarding, built with RF_WB_FORWARD_EN: rf_write=1, rf_addr=3, rf_data=0xBEEF, rd_addr1=3, rf_rdata1=0x0000 → rd_data1=0xBEEF. With rd_addr1=1 → rd_data1=rf_rdata1. Built without the macro → rd_data1=0x0000.
- Counter saturation: force 0xFFFF contention cycles → conflict_cnt holds at 0xFFFF.
